// File: rtl/reg_read_stage_pkg.sv
// Shared constants and state encoding for the register-bank read stage.
package reg_read_stage_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int CNT_W    = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/reg_read_stage_if.sv
// Bank, decoder and ALU-side signals of the read stage.
interface reg_read_stage_if;
  import reg_read_stage_pkg::*;

  logic [NUM_REGS*DATA_W-1:0] reg_flat;
  logic [NUM_REGS-1:0]        wr_enable;
  logic [DATA_W-1:0]          wr_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [ADDR_W-1:0]          src_addr;
  logic [ADDR_W-1:0]          dst_addr;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          a_out;
  logic [DATA_W-1:0]          b_out;
  logic [ADDR_W-1:0]          a_addr_q;
  logic [ADDR_W-1:0]          b_addr_q;
  logic [CNT_W-1:0]           stall_cnt;

  // The read stage itself.
  modport slave (
    input  reg_flat, wr_enable, wr_data, in_valid, src_addr, dst_addr, out_ready,
    output in_ready, out_valid, a_out, b_out, a_addr_q, b_addr_q, stall_cnt
  );

  // The decoder / bank / ALU environment around the stage.
  modport master (
    output reg_flat, wr_enable, wr_data, in_valid, src_addr, dst_addr, out_ready,
    input  in_ready, out_valid, a_out, b_out, a_addr_q, b_addr_q, stall_cnt
  );

endinterface

// File: rtl/reg_read_stage_mux.sv
// 16:1 word select from the bank outputs, bypassed by the ALU bus when
// the addressed register is being written this cycle.
module reg_read_mux
  import reg_read_stage_pkg::*;
(
  input  logic [NUM_REGS*DATA_W-1:0] i_reg_flat,
  input  logic [NUM_REGS-1:0]        i_wr_enable,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic [ADDR_W-1:0]          i_addr,
  output logic [DATA_W-1:0]          o_word
);

  // Every enabled register receives the same bus value, so only the
  // addressed enable bit matters for forwarding.
  always_comb begin
    o_word = i_reg_flat[int'(i_addr)*DATA_W +: DATA_W];
    if (i_wr_enable[i_addr]) begin
      o_word = i_wr_data;
    end
  end

endmodule

// File: rtl/reg_read_stage.sv
// Operand read stage: selects Rsrc/Rdest from the register bank, registers
// them for the ALU behind a one-deep valid/ready slot.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_EMPTY | no operand pair held, out_valid=0
//   ST_FULL  | operand pair held for the ALU, out_valid=1
module reg_read_stage
  import reg_read_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  reg_read_stage_if.slave bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [ADDR_W-1:0] r_a_addr;
  logic [ADDR_W-1:0] r_b_addr;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [DATA_W-1:0] w_a_sel;
  logic [DATA_W-1:0] w_b_sel;
  logic              w_out_valid;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_consume;
  logic              w_hold;

  reg_read_mux u_mux_src (
    .i_reg_flat  (bus.reg_flat),
    .i_wr_enable (bus.wr_enable),
    .i_wr_data   (bus.wr_data),
    .i_addr      (bus.src_addr),
    .o_word      (w_a_sel)
  );

  reg_read_mux u_mux_dst (
    .i_reg_flat  (bus.reg_flat),
    .i_wr_enable (bus.wr_enable),
    .i_wr_data   (bus.wr_data),
    .i_addr      (bus.dst_addr),
    .o_word      (w_b_sel)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: fill on accept, drain when consumed without a refill.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL:  if (w_consume && !w_accept) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Handshake outputs; in_ready passes out_ready through so a full slot
  // can be refilled in the same cycle it drains.
  always_comb begin
    w_out_valid = (r_state == ST_FULL);
    w_in_ready  = !w_out_valid || bus.out_ready;
    w_accept    = bus.in_valid && w_in_ready;
    w_consume   = w_out_valid && bus.out_ready;
    w_hold      = w_out_valid && !bus.out_ready;
  end

  // Operand capture on accept; while held, track writes to the held registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_a_addr <= '0;
      r_b_addr <= '0;
    end else if (w_accept) begin
      r_a      <= w_a_sel;
      r_b      <= w_b_sel;
      r_a_addr <= bus.src_addr;
      r_b_addr <= bus.dst_addr;
    end else if (w_hold) begin
      if (bus.wr_enable[r_a_addr]) r_a <= bus.wr_data;
      if (bus.wr_enable[r_b_addr]) r_b <= bus.wr_data;
    end
  end

  // Saturating count of back-pressured cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.a_out     = r_a;
  assign bus.b_out     = r_b;
  assign bus.a_addr_q  = r_a_addr;
  assign bus.b_addr_q  = r_b_addr;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage with an expected-pair scoreboard.
module tb_reg_read_stage;
  import reg_read_stage_pkg::*;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] aa;
    logic [ADDR_W-1:0] ba;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  reg_read_stage_if bus();

  reg_read_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t              q[$];
  logic [DATA_W-1:0] bank [NUM_REGS];
  logic [CNT_W-1:0]  exp_stall;
  int                nchk  = 0;
  int                npass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] a,
                                           input logic [NUM_REGS-1:0] we,
                                           input logic [DATA_W-1:0] wd);
    return we[a] ? wd : bank[a];
  endfunction

  task automatic drive_bank();
    for (int i = 0; i < NUM_REGS; i++) bus.reg_flat[i*DATA_W +: DATA_W] = bank[i];
  endtask

  // One clock: drive at negedge, check the held pair, advance the model,
  // then apply the bank writes after the edge.
  task automatic step(input logic iv, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                      input logic ordy, input logic [NUM_REGS-1:0] we,
                      input logic [DATA_W-1:0] wd);
    logic m_valid;
    logic m_ready;
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.src_addr  = s;
    bus.dst_addr  = d;
    bus.out_ready = ordy;
    bus.wr_enable = we;
    bus.wr_data   = wd;
    #1;
    m_valid = (q.size() != 0);
    m_ready = !m_valid || ordy;
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, m_ready});
    if (m_valid) begin
      e = q[0];
      chk("a_out",    32'(bus.a_out),    32'(e.a));
      chk("b_out",    32'(bus.b_out),    32'(e.b));
      chk("a_addr_q", 32'(bus.a_addr_q), 32'(e.aa));
      chk("b_addr_q", 32'(bus.b_addr_q), 32'(e.ba));
      if (ordy) begin
        void'(q.pop_front());
      end else begin
        if (we[e.aa]) e.a = wd;
        if (we[e.ba]) e.b = wd;
        q[0] = e;
        if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      end
    end
    if (iv && m_ready) begin
      e.a  = fwd(s, we, wd);
      e.b  = fwd(d, we, wd);
      e.aa = s;
      e.ba = d;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REGS; i++) if (we[i]) bank[i] = wd;
    drive_bank();
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.src_addr  = '0;
    bus.dst_addr  = '0;
    bus.out_ready = 1'b0;
    bus.wr_enable = '0;
    bus.wr_data   = '0;
    for (int i = 0; i < NUM_REGS; i++) bank[i] = 16'h1000 + 16'(i) * 16'h0111;
    bank[3] = 16'h1234;
    bank[7] = 16'hBEEF;
    bank[5] = 16'h0001;
    drive_bank();
    exp_stall = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_a_out",     32'(bus.a_out),     32'd0);
    chk("rst_b_out",     32'(bus.b_out),     32'd0);
    chk("rst_a_addr_q",  32'(bus.a_addr_q),  32'd0);
    chk("rst_b_addr_q",  32'(bus.b_addr_q),  32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Plain read r3/r7
    step(1'b1, 4'd3, 4'd7, 1'b1, 16'h0000, 16'h0000);
    step(1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 16'h0000);

    // Forward r5 from the ALU bus in the accept cycle
    step(1'b1, 4'd5, 4'd9, 1'b1, 16'h0020, 16'hA5A5);
    // Same register on both operands, several write enables set
    step(1'b1, 4'd4, 4'd4, 1'b1, 16'h0410, 16'h5A5A);
    step(1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 16'h0000);

    // Stall with refresh of a then b
    step(1'b1, 4'd2, 4'd6, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 4'd0, 4'd0, 1'b0, 16'h0004, 16'h7777);
    step(1'b1, 4'd9, 4'd9, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 4'd0, 4'd0, 1'b0, 16'h0040, 16'h4242);
    step(1'b0, 4'd0, 4'd0, 1'b0, 16'h0100, 16'h3131);
    // Consume and accept together: new forwarded capture wins over refresh
    step(1'b1, 4'd2, 4'd6, 1'b1, 16'h0004, 16'h9999);
    step(1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 16'h0000);

    // Back-to-back streaming, eight pairs
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 4'(15 - i), 1'b1, 16'h0000, 16'h0000);
    step(1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 16'h0000);
    step(1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 16'h0000);

    // Asynchronous reset while full and stalled
    step(1'b1, 4'd8, 4'd9, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 16'h0000);
    #2;
    reset = 1'b1;
    #1;
    chk("amid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("amid_a_out",     32'(bus.a_out),     32'd0);
    chk("amid_b_out",     32'(bus.b_out),     32'd0);
    chk("amid_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    q.delete();
    exp_stall = '0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 16'h0000);

    // Counter saturation over 70000 stalled cycles
    step(1'b1, 4'd10, 4'd11, 1'b0, 16'h0000, 16'h0000);
    bus.in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    exp_stall = 16'hFFFF;
    chk("sat_stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
    step(1'b0, 4'd0, 4'd0, 1'b0, 16'h0000, 16'h0000);
    step(1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 16'h0000);
    step(1'b0, 4'd0, 4'd0, 1'b1, 16'h0000, 16'h0000);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
